// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module : i2c_pkg
// Purpose: Shared types and constants for the I2C register-file port:
//          protocol FSM state encoding, byte width, ACK polarity and the
//          bit-count value that marks a complete byte.
// Revision: 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam int         I2C_BYTE_W = 8;
  localparam logic       ACK_BIT    = 1'b0;
  localparam logic [3:0] LAST_BIT   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PTR       = 3'd1,
    ST_WR_DATA   = 3'd2,
    ST_RD_DATA   = 3'd3,
    ST_RD_ACK    = 3'd4,
    ST_WAIT_STOP = 3'd5
  } state_e;

endpackage
`default_nettype wire

// File: rtl/i2c_byte_shifter.sv
`default_nettype none
// ============================================================================
// Module : i2c_byte_shifter
// Purpose: 8-bit MSB-first shift register with parallel load and a 0..8
//          bit counter, shared by the receive and transmit paths.
// Ports  : clk, rst     - clock, asynchronous active-high reset
//          load_i       - parallel load of load_data_i (counter -> 0)
//          load_data_i  - byte to load
//          shift_i      - shift left by one, sin_i enters at bit 0
//          sin_i        - serial input bit
//          clr_i        - clear the bit counter only
//          data_o       - current register contents (bit 7 = next out)
//          cnt_o        - number of bits shifted since load/clear
// Revision: 1.0 - initial release
// ============================================================================
module i2c_byte_shifter
  import i2c_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [I2C_BYTE_W-1:0] load_data_i,
  input  logic                  shift_i,
  input  logic                  sin_i,
  input  logic                  clr_i,
  output logic [I2C_BYTE_W-1:0] data_o,
  output logic [3:0]            cnt_o
);

  logic [I2C_BYTE_W-1:0] data_q, data_d;
  logic [3:0]            cnt_q, cnt_d;

  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      // Load and shift together: the MSB leaves in the same cycle it
      // arrives, so one bit is already counted as sent.
      data_d = shift_i ? {load_data_i[I2C_BYTE_W-2:0], sin_i} : load_data_i;
      cnt_d  = shift_i ? 4'd1 : 4'd0;
    end else if (clr_i) begin
      cnt_d = 4'd0;
    end else if (shift_i && (cnt_q < LAST_BIT)) begin
      data_d = {data_q[I2C_BYTE_W-2:0], sin_i};
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      cnt_q  <= 4'd0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_q;
  assign cnt_o  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/i2c_regfile_port.sv
`default_nettype none
// ============================================================================
// Module : i2c_regfile_port
// Purpose: I2C subordinate register file. The first written byte sets the
//          auto-incrementing pointer, following bytes are written in a
//          burst; reads stream bytes from the pointer. A host-side port
//          gives combinational reads and clocked writes into the same array.
// Ports  : clk, rst            - system clock, asynchronous active-high reset
//          scl_rise_i/_fall_i  - one-clk SCL edge strobes
//          sda_in_i            - synchronised SDA level
//          stop_det_i          - STOP / repeated START strobe
//          xfer_start_i        - own address acked (with the ACK's SCL fall)
//          xfer_rw_i           - R/W bit, 1 = read
//          sda_oe_o            - 1 = pull SDA low
//          host_addr_i/_we_i/_wdata_i/_rdata_o - host access port
//          host_collision_o    - one-clk pulse when a host write is dropped
//          ptr_o, busy_o       - debug pointer, state != IDLE
// Revision: 1.0 - initial release
// ============================================================================
module i2c_regfile_port
  import i2c_pkg::*;
#(
  parameter int unsigned ADDR_W    = 7,
  parameter bit          WRAP_EN   = 1'b1,
  parameter logic [7:0]  RESET_VAL = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_rise_i,
  input  logic              scl_fall_i,
  input  logic              sda_in_i,
  input  logic              stop_det_i,
  input  logic              xfer_start_i,
  input  logic              xfer_rw_i,
  output logic              sda_oe_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic              host_we_i,
  input  logic [7:0]        host_wdata_i,
  output logic [7:0]        host_rdata_o,
  output logic              host_collision_o,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              busy_o
);

  localparam int unsigned       c_DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] c_PTR_MAX = {ADDR_W{1'b1}};

  state_e            state_q, state_d;
  logic              sda_oe_q, sda_oe_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;   // saturated write: next byte is NACKed
  logic              coll_q;
  logic [7:0]        mem_q [c_DEPTH];

  logic              w_sh_load, w_sh_shift, w_sh_sin, w_sh_clr;
  logic [7:0]        w_sh_data;
  logic [3:0]        w_sh_cnt;
  logic              w_cnt_full;
  logic              w_i2c_we;
  logic              w_host_coll;
  logic              w_byte_fits;
  logic [ADDR_W-1:0] w_ptr_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [7:0]        w_rd_byte;

  i2c_byte_shifter u_shifter (
    .clk         (clk),
    .rst         (rst),
    .load_i      (w_sh_load),
    .load_data_i (w_rd_byte),
    .shift_i     (w_sh_shift),
    .sin_i       (w_sh_sin),
    .clr_i       (w_sh_clr),
    .data_o      (w_sh_data),
    .cnt_o       (w_sh_cnt)
  );

  assign w_cnt_full  = (w_sh_cnt == LAST_BIT);
  assign w_byte_fits = ((w_sh_data >> ADDR_W) == 8'd0);
  assign w_ptr_next  = ((ptr_q == c_PTR_MAX) && !WRAP_EN) ? ptr_q : ptr_q + ADDR_W'(1);
  // A master ACK reloads from the advanced pointer; every other load
  // (start of a read) uses the current pointer.
  assign w_rd_addr   = (state_q == ST_RD_ACK) ? w_ptr_next : ptr_q;
  assign w_rd_byte   = mem_q[w_rd_addr];
  assign w_host_coll = host_we_i && w_i2c_we && (host_addr_i == ptr_q);

  always_comb begin
    state_d    = state_q;
    sda_oe_d   = sda_oe_q;
    ptr_d      = ptr_q;
    full_d     = full_q;
    w_sh_load  = 1'b0;
    w_sh_shift = 1'b0;
    w_sh_sin   = sda_in_i;
    w_sh_clr   = 1'b0;
    w_i2c_we   = 1'b0;
    if (stop_det_i) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      w_sh_clr = 1'b1;
      full_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          sda_oe_d = 1'b0;
          full_d   = 1'b0;
          if (xfer_start_i) begin
            if (xfer_rw_i) begin
              // Load the byte and drive its MSB off this same SCL fall.
              w_sh_load  = 1'b1;
              w_sh_shift = 1'b1;
              w_sh_sin   = 1'b0;
              sda_oe_d   = ~w_rd_byte[7];
              state_d    = ST_RD_DATA;
            end else begin
              w_sh_clr = 1'b1;
              state_d  = ST_PTR;
            end
          end
        end
        ST_PTR, ST_WR_DATA: begin
          if (scl_rise_i && !w_cnt_full) begin
            w_sh_shift = 1'b1;
          end else if (scl_fall_i && w_cnt_full) begin
            if (sda_oe_q) begin
              // End of our ACK bit: release SDA, start the next byte.
              sda_oe_d = 1'b0;
              w_sh_clr = 1'b1;
            end else if (state_q == ST_PTR) begin
              if (w_byte_fits) begin
                ptr_d    = w_sh_data[ADDR_W-1:0];
                sda_oe_d = 1'b1;
                state_d  = ST_WR_DATA;
              end else begin
                state_d = ST_WAIT_STOP;
              end
            end else if (full_q) begin
              state_d = ST_WAIT_STOP;
            end else begin
              w_i2c_we = 1'b1;
              sda_oe_d = 1'b1;
              full_d   = (ptr_q == c_PTR_MAX) && !WRAP_EN;
              ptr_d    = w_ptr_next;
            end
          end
        end
        ST_RD_DATA: begin
          if (scl_fall_i) begin
            if (!w_cnt_full) begin
              sda_oe_d   = ~w_sh_data[7];
              w_sh_shift = 1'b1;
              w_sh_sin   = 1'b0;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = ST_RD_ACK;
            end
          end
        end
        ST_RD_ACK: begin
          if (scl_rise_i) begin
            if (sda_in_i == ACK_BIT) begin
              ptr_d     = w_ptr_next;
              w_sh_load = 1'b1;
              state_d   = ST_RD_DATA;
            end else begin
              state_d = ST_WAIT_STOP;
            end
          end
        end
        ST_WAIT_STOP: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = ST_IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sda_oe_q <= 1'b0;
      ptr_q    <= '0;
      full_q   <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sda_oe_q <= sda_oe_d;
      ptr_q    <= ptr_d;
      full_q   <= full_d;
      coll_q   <= w_host_coll;
    end
  end

  // The I2C write wins a same-address collision; the host write is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(c_DEPTH); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else begin
      if (host_we_i && !w_host_coll) begin
        mem_q[host_addr_i] <= host_wdata_i;
      end
      if (w_i2c_we) begin
        mem_q[ptr_q] <= w_sh_data;
      end
    end
  end

  assign sda_oe_o         = sda_oe_q;
  assign host_rdata_o     = mem_q[host_addr_i];
  assign host_collision_o = coll_q;
  assign ptr_o            = ptr_q;
  assign busy_o           = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_regfile_port.sv
`default_nettype none
// ============================================================================
// Module : tb_i2c_regfile_port
// Purpose: Self-checking bench for i2c_regfile_port. Three instances cover
//          wrap (default), saturate (WRAP_EN=0) and a 16-byte array
//          (ADDR_W=4). Stimulus pushes expected values into a queue; a
//          monitor pops and compares when the DUT presents a bit on SDA or
//          when a probe strobe asks for a register/array value.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_regfile_port;

  localparam int K_SDA  = 0;
  localparam int K_PTR  = 1;
  localparam int K_BUSY = 2;
  localparam int K_MEM  = 3;
  localparam int K_COLL = 4;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] exp;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, scl_rise, scl_fall, sda_in, stop_det, xfer_start, xfer_rw;
  logic       host_we, drv_slot, probe_v, coll_arm;
  logic [7:0] host_addr, host_wdata;
  int         sel;

  logic       oe_a, oe_b, oe_c, coll_a, coll_b, coll_c, busy_a, busy_b, busy_c;
  logic [7:0] rd_a, rd_b, rd_c;
  logic [6:0] ptr_a, ptr_b;
  logic [3:0] ptr_c;
  logic       xs_a, xs_b, xs_c;
  logic       m_oe, m_coll, m_busy;
  logic [7:0] m_rd, m_ptr;

  item_t      sb_q[$];
  item_t      it;
  logic [7:0] act;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         coll_cycles = 0;

  assign xs_a = xfer_start && (sel == 0);
  assign xs_b = xfer_start && (sel == 1);
  assign xs_c = xfer_start && (sel == 2);

  i2c_regfile_port u_dut_a (
    .clk(clk), .rst(rst), .scl_rise_i(scl_rise), .scl_fall_i(scl_fall),
    .sda_in_i(sda_in), .stop_det_i(stop_det), .xfer_start_i(xs_a),
    .xfer_rw_i(xfer_rw), .sda_oe_o(oe_a), .host_addr_i(host_addr[6:0]),
    .host_we_i(host_we), .host_wdata_i(host_wdata), .host_rdata_o(rd_a),
    .host_collision_o(coll_a), .ptr_o(ptr_a), .busy_o(busy_a)
  );

  i2c_regfile_port #(.WRAP_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .scl_rise_i(scl_rise), .scl_fall_i(scl_fall),
    .sda_in_i(sda_in), .stop_det_i(stop_det), .xfer_start_i(xs_b),
    .xfer_rw_i(xfer_rw), .sda_oe_o(oe_b), .host_addr_i(host_addr[6:0]),
    .host_we_i(1'b0), .host_wdata_i(8'h00), .host_rdata_o(rd_b),
    .host_collision_o(coll_b), .ptr_o(ptr_b), .busy_o(busy_b)
  );

  i2c_regfile_port #(.ADDR_W(4)) u_dut_c (
    .clk(clk), .rst(rst), .scl_rise_i(scl_rise), .scl_fall_i(scl_fall),
    .sda_in_i(sda_in), .stop_det_i(stop_det), .xfer_start_i(xs_c),
    .xfer_rw_i(xfer_rw), .sda_oe_o(oe_c), .host_addr_i(host_addr[3:0]),
    .host_we_i(1'b0), .host_wdata_i(8'h00), .host_rdata_o(rd_c),
    .host_collision_o(coll_c), .ptr_o(ptr_c), .busy_o(busy_c)
  );

  always_comb begin
    m_oe = oe_a; m_coll = coll_a; m_busy = busy_a; m_rd = rd_a; m_ptr = {1'b0, ptr_a};
    if (sel == 1) begin
      m_oe = oe_b; m_coll = coll_b; m_busy = busy_b; m_rd = rd_b; m_ptr = {1'b0, ptr_b};
    end else if (sel == 2) begin
      m_oe = oe_c; m_coll = coll_c; m_busy = busy_c; m_rd = rd_c; m_ptr = {4'd0, ptr_c};
    end
  end

  // Monitor: pops one expectation per SDA bit presented or per probe strobe.
  always @(negedge clk) begin
    if (m_coll) coll_cycles++;
    if ((scl_rise && drv_slot) || probe_v) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: got an output with no expected item queued");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          K_SDA:   act = {7'd0, m_oe};
          K_PTR:   act = m_ptr;
          K_BUSY:  act = {7'd0, m_busy};
          K_MEM:   act = m_rd;
          default: act = coll_cycles[7:0];
        endcase
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got 0x%02h, expected 0x%02h", it.tag, act, it.exp);
        end
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input int kind, input logic [7:0] exp);
    item_t x;
    x.tag = tag; x.kind = kind; x.exp = exp;
    sb_q.push_back(x);
  endtask

  task automatic probe(input string tag, input int kind, input logic [7:0] addr,
                       input logic [7:0] exp);
    host_addr = addr;
    push(tag, kind, exp);
    probe_v = 1'b1;
    @(negedge clk);
    #1 probe_v = 1'b0;
  endtask

  // One SCL clock: data set while low, rise, then fall.
  task automatic i2c_bit(input logic sda, input logic chk);
    tick(); sda_in = sda;
    tick(); drv_slot = chk; scl_rise = 1'b1;
    tick(); scl_rise = 1'b0; drv_slot = 1'b0;
    tick(); scl_fall = 1'b1;
    if (coll_arm) host_we = 1'b1;
    tick(); scl_fall = 1'b0; host_we = 1'b0; coll_arm = 1'b0;
  endtask

  task automatic start_xfer(input logic rw);
    tick(); scl_fall = 1'b1; xfer_start = 1'b1; xfer_rw = rw;
    tick(); scl_fall = 1'b0; xfer_start = 1'b0;
  endtask

  task automatic stop_xfer();
    tick(); tick(); stop_det = 1'b1;
    tick(); stop_det = 1'b0;
    tick();
  endtask

  // Master writes b; arm makes the host write collide with the commit edge.
  task automatic write_byte(input string tag, input logic [7:0] b,
                            input logic ack, input logic arm);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && arm) coll_arm = 1'b1;
      i2c_bit(b[i], 1'b0);
    end
    push({tag, "_ack"}, K_SDA, {7'd0, ack});
    i2c_bit(1'b1, 1'b1);
  endtask

  task automatic read_byte(input string tag, input logic [7:0] b, input logic mack);
    for (int i = 7; i >= 0; i--) begin
      push($sformatf("%s_b%0d", tag, i), K_SDA, {7'd0, ~b[i]});
      i2c_bit(1'b1, 1'b1);
    end
    push({tag, "_mack_rel"}, K_SDA, 8'h00);
    i2c_bit(~mack, 1'b1);
  endtask

  logic [7:0] bv;

  initial begin
    rst = 1'b1; scl_rise = 0; scl_fall = 0; sda_in = 1; stop_det = 0;
    xfer_start = 0; xfer_rw = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    drv_slot = 0; probe_v = 0; coll_arm = 0; sel = 0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    probe("rst_ptr",  K_PTR,  8'h00, 8'h00);
    probe("rst_busy", K_BUSY, 8'h00, 8'h00);
    probe("rst_oe",   K_SDA,  8'h00, 8'h00);
    probe("rst_mem",  K_MEM,  8'h10, 8'h00);

    // Write burst
    start_xfer(1'b0);
    write_byte("wb_ptr", 8'h10, 1'b1, 1'b0);
    write_byte("wb_d0",  8'hA5, 1'b1, 1'b0);
    write_byte("wb_d1",  8'h5A, 1'b1, 1'b0);
    stop_xfer();
    probe("wb_mem10", K_MEM, 8'h10, 8'hA5);
    probe("wb_mem11", K_MEM, 8'h11, 8'h5A);
    probe("wb_ptr12", K_PTR, 8'h00, 8'h12);
    probe("wb_idle",  K_BUSY, 8'h00, 8'h00);

    // Host write then read burst from 0x10
    host_addr = 8'h12; host_wdata = 8'h3C; host_we = 1'b1;
    tick(); host_we = 1'b0;
    probe("host_mem12", K_MEM, 8'h12, 8'h3C);
    start_xfer(1'b0);
    write_byte("rb_ptr", 8'h10, 1'b1, 1'b0);
    stop_xfer();
    start_xfer(1'b1);
    read_byte("rb0", 8'hA5, 1'b1);
    read_byte("rb1", 8'h5A, 1'b1);
    read_byte("rb2", 8'h3C, 1'b0);
    probe("rb_wait_busy", K_BUSY, 8'h00, 8'h01);
    probe("rb_ptr", K_PTR, 8'h00, 8'h12);
    stop_xfer();
    probe("rb_idle", K_BUSY, 8'h00, 8'h00);

    // Same-address collision: I2C wins, one-clk pulse
    start_xfer(1'b0);
    write_byte("co_ptr", 8'h11, 1'b1, 1'b0);
    host_addr = 8'h11; host_wdata = 8'hEE;
    write_byte("co_d", 8'h77, 1'b1, 1'b1);
    stop_xfer();
    probe("co_mem11", K_MEM,  8'h11, 8'h77);
    probe("co_pulse", K_COLL, 8'h00, 8'h01);

    // Different addresses: both commit, no pulse
    start_xfer(1'b0);
    write_byte("nc_ptr", 8'h20, 1'b1, 1'b0);
    host_addr = 8'h30; host_wdata = 8'h99;
    write_byte("nc_d", 8'h44, 1'b1, 1'b1);
    stop_xfer();
    probe("nc_mem20", K_MEM,  8'h20, 8'h44);
    probe("nc_mem30", K_MEM,  8'h30, 8'h99);
    probe("nc_pulse", K_COLL, 8'h00, 8'h01);

    // Wrap at DEPTH-1
    start_xfer(1'b0);
    write_byte("wr_ptr", 8'h7F, 1'b1, 1'b0);
    write_byte("wr_d0",  8'h11, 1'b1, 1'b0);
    write_byte("wr_d1",  8'h22, 1'b1, 1'b0);
    stop_xfer();
    probe("wr_mem7f", K_MEM, 8'h7F, 8'h11);
    probe("wr_mem00", K_MEM, 8'h00, 8'h22);
    probe("wr_ptr01", K_PTR, 8'h00, 8'h01);

    // Reset during a read, after three bits of 0xA5
    start_xfer(1'b0);
    write_byte("rr_ptr", 8'h10, 1'b1, 1'b0);
    stop_xfer();
    bv = 8'hA5;
    start_xfer(1'b1);
    for (int i = 7; i >= 5; i--) begin
      push($sformatf("rr_b%0d", i), K_SDA, {7'd0, ~bv[i]});
      i2c_bit(1'b1, 1'b1);
    end
    tick();
    probe("rr_pre_oe", K_SDA, 8'h00, 8'h01);
    @(posedge clk);
    #1 rst = 1'b1;
    probe("rr_oe",   K_SDA,  8'h10, 8'h00);
    probe("rr_busy", K_BUSY, 8'h10, 8'h00);
    probe("rr_ptr",  K_PTR,  8'h10, 8'h00);
    probe("rr_mem",  K_MEM,  8'h10, 8'h00);
    tick(); rst = 1'b0; tick();
    start_xfer(1'b0);
    write_byte("ar_ptr", 8'h05, 1'b1, 1'b0);
    write_byte("ar_d",   8'hC3, 1'b1, 1'b0);
    stop_xfer();
    start_xfer(1'b0);
    write_byte("ar_ptr2", 8'h05, 1'b1, 1'b0);
    stop_xfer();
    start_xfer(1'b1);
    read_byte("ar_rd", 8'hC3, 1'b0);
    stop_xfer();
    probe("ar_mem05", K_MEM, 8'h05, 8'hC3);
    probe("ar_ptr05", K_PTR, 8'h00, 8'h05);

    // Saturate (WRAP_EN=0): third byte NACKed, reads repeat last byte
    sel = 1;
    start_xfer(1'b0);
    write_byte("sa_ptr", 8'h7F, 1'b1, 1'b0);
    write_byte("sa_d0",  8'hAB, 1'b1, 1'b0);
    write_byte("sa_d1",  8'hCD, 1'b0, 1'b0);
    probe("sa_wait", K_BUSY, 8'h00, 8'h01);
    stop_xfer();
    probe("sa_mem7f", K_MEM, 8'h7F, 8'hAB);
    probe("sa_mem00", K_MEM, 8'h00, 8'h00);
    probe("sa_ptr",   K_PTR, 8'h00, 8'h7F);
    start_xfer(1'b1);
    read_byte("sa_r0", 8'hAB, 1'b1);
    read_byte("sa_r1", 8'hAB, 1'b0);
    stop_xfer();
    probe("sa_rptr", K_PTR, 8'h00, 8'h7F);

    // Out-of-range pointer on a 16-byte array
    sel = 2;
    start_xfer(1'b0);
    write_byte("bp_set", 8'h03, 1'b1, 1'b0);
    stop_xfer();
    start_xfer(1'b0);
    write_byte("bp_ptr", 8'h20, 1'b0, 1'b0);
    write_byte("bp_d",   8'h55, 1'b0, 1'b0);
    probe("bp_wait", K_BUSY, 8'h00, 8'h01);
    stop_xfer();
    probe("bp_ptr3", K_PTR, 8'h00, 8'h03);
    probe("bp_mem0", K_MEM, 8'h00, 8'h00);
    probe("bp_mem3", K_MEM, 8'h03, 8'h00);

    repeat (5) tick();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d items left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
